// File: rtl/gpr_pkg.sv
// Shared constants and enums for the GPR write-port arbiter slice.
package gpr_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREG   = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// Writeback request/acknowledge bundle plus the registered gpr write port.
interface gpr_wb_arbiter_if #(
  parameter int DATA_W = gpr_pkg::DATA_W,
  parameter int ADDR_W = gpr_pkg::ADDR_W
);

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_dest;
  logic [DATA_W-1:0] alu_data;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_dest;
  logic [DATA_W-1:0] mem_data;

  logic              gpr_write_en;
  logic [ADDR_W-1:0] gpr_write_dest;
  logic [DATA_W-1:0] gpr_write_data;
  logic              busy;

  // Requester/observer side
  modport master (
    output alu_valid, alu_dest, alu_data,
    output mem_valid, mem_dest, mem_data,
    input  alu_ready, mem_ready,
    input  gpr_write_en, gpr_write_dest, gpr_write_data, busy
  );

  // Arbiter side
  modport slave (
    input  alu_valid, alu_dest, alu_data,
    input  mem_valid, mem_dest, mem_data,
    output alu_ready, mem_ready,
    output gpr_write_en, gpr_write_dest, gpr_write_data, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; grant[0]=ALU, grant[1]=MEM, one-hot or zero.
module rr_arb2
  import gpr_pkg::*;
(
  input  logic       req_alu,
  input  logic       req_mem,
  input  req_id_e    last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req_alu && req_mem) begin
      grant = (last_grant == REQ_MEM) ? 2'b01 : 2'b10;
    end else if (req_alu) begin
      grant = 2'b01;
    end else if (req_mem) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// GPR write-port controller: clears r0..r(NREG-1) after reset, then
// round-robin shares the single write port between ALU and load writeback.
module gpr_wb_arbiter #(
  parameter int DATA_W = gpr_pkg::DATA_W,
  parameter int ADDR_W = gpr_pkg::ADDR_W,
  parameter int NREG   = gpr_pkg::NREG
) (
  input  logic           clk,
  input  logic           rst_n,
  gpr_wb_arbiter_if.slave bus
);

  import gpr_pkg::*;

  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(NREG - 1);
  localparam logic [ADDR_W:0] CLR_ONE  = (ADDR_W+1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   clr_idx_q, clr_idx_d;
  req_id_e           last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [1:0]        grant;
  logic              alu_ready, mem_ready, busy;
  logic              alu_xfer, mem_xfer;

  rr_arb2 u_arb (
    .req_alu    (bus.alu_valid),
    .req_mem    (bus.mem_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= CLEAR;
      clr_idx_q    <= '0;
      last_grant_q <= REQ_MEM;
      we_q         <= 1'b0;
      dest_q       <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      dest_q       <= dest_d;
      data_q       <= data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    last_grant_d = last_grant_q;
    we_d         = 1'b0;
    dest_d       = dest_q;
    data_d       = data_q;
    case (state_q)
      CLEAR: begin
        we_d      = 1'b1;
        dest_d    = clr_idx_q[ADDR_W-1:0];
        data_d    = '0;
        clr_idx_d = clr_idx_q + CLR_ONE;
        if (clr_idx_q == CLR_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // r0 is hardwired zero: the handshake completes but nothing is written
        if (alu_xfer) begin
          we_d         = (bus.alu_dest != '0);
          dest_d       = bus.alu_dest;
          data_d       = bus.alu_data;
          last_grant_d = REQ_ALU;
        end else if (mem_xfer) begin
          we_d         = (bus.mem_dest != '0);
          dest_d       = bus.mem_dest;
          data_d       = bus.mem_data;
          last_grant_d = REQ_MEM;
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_comb begin
    busy      = (state_q == CLEAR);
    alu_ready = (state_q == RUN) && grant[0];
    mem_ready = (state_q == RUN) && grant[1];
    alu_xfer  = bus.alu_valid && alu_ready;
    mem_xfer  = bus.mem_valid && mem_ready;
  end

  assign bus.alu_ready      = alu_ready;
  assign bus.mem_ready      = mem_ready;
  assign bus.busy           = busy;
  assign bus.gpr_write_en   = we_q;
  assign bus.gpr_write_dest = dest_q;
  assign bus.gpr_write_data = data_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Randomized + directed bench for gpr_wb_arbiter against a cycle-level behavioural model.
module tb_gpr_wb_arbiter;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gpr_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  gpr_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NREG(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Register file stand-in, fed from the DUT write port
  logic [DW-1:0] gpr_mem [NR];
  always @(posedge clk) begin
    if (bus.gpr_write_en) gpr_mem[bus.gpr_write_dest] <= bus.gpr_write_data;
  end

  int total = 0;
  int bad   = 0;

  // Requester state
  bit            a_pend, m_pend, a_rep, m_rep;
  logic [AW-1:0] a_dest, m_dest;
  logic [DW-1:0] a_data, m_data;

  // Reference model state
  int            clr_cnt;
  bit            last_mem;
  logic [DW-1:0] exp_regs [NR];
  bit            shown_we;
  logic [AW-1:0] shown_dest;
  logic [DW-1:0] shown_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic drive();
    bus.alu_valid = a_pend;
    bus.alu_dest  = a_dest;
    bus.alu_data  = a_data;
    bus.mem_valid = m_pend;
    bus.mem_dest  = m_dest;
    bus.mem_data  = m_data;
  endtask

  // One clock: check readies/busy mid-cycle, then the registered write after the edge
  task automatic step();
    int            win;
    bit            nxt_we;
    logic [AW-1:0] nxt_dest;
    logic [DW-1:0] nxt_data;
    win = 0;
    @(negedge clk);
    if (rst_n) begin
      if (clr_cnt < NR) begin
        chk("busy", 32'(bus.busy), 32'd1);
        chk("alu_ready_clr", 32'(bus.alu_ready), 32'd0);
        chk("mem_ready_clr", 32'(bus.mem_ready), 32'd0);
        nxt_we   = 1'b1;
        nxt_dest = AW'(clr_cnt);
        nxt_data = '0;
        clr_cnt++;
      end else begin
        chk("busy", 32'(bus.busy), 32'd0);
        if (a_pend && m_pend) win = last_mem ? 1 : 2;
        else if (a_pend)      win = 1;
        else if (m_pend)      win = 2;
        chk("alu_ready", 32'(bus.alu_ready), 32'(win == 1));
        chk("mem_ready", 32'(bus.mem_ready), 32'(win == 2));
        nxt_we   = 1'b0;
        nxt_dest = shown_dest;
        nxt_data = shown_data;
        if (win == 1) begin
          nxt_we = (a_dest != 0); nxt_dest = a_dest; nxt_data = a_data; last_mem = 1'b0;
        end else if (win == 2) begin
          nxt_we = (m_dest != 0); nxt_dest = m_dest; nxt_data = m_data; last_mem = 1'b1;
        end
      end
    end else begin
      nxt_we = 1'b0; nxt_dest = '0; nxt_data = '0;
      clr_cnt = 0;
      last_mem = 1'b1;
    end
    @(posedge clk);
    if (shown_we) exp_regs[shown_dest] = shown_data;
    shown_we = nxt_we; shown_dest = nxt_dest; shown_data = nxt_data;
    #1;
    chk("write_en", 32'(bus.gpr_write_en), 32'(shown_we));
    chk("write_dest", 32'(bus.gpr_write_dest), 32'(shown_dest));
    chk("write_data", 32'(bus.gpr_write_data), 32'(shown_data));
    if (win == 1) begin
      $display("xfer ALU dest=%0d data=%h", a_dest, a_data);
      if (!a_rep) a_pend = 1'b0;
    end else if (win == 2) begin
      $display("xfer MEM dest=%0d data=%h", m_dest, m_data);
      if (!m_rep) m_pend = 1'b0;
    end
    drive();
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++) chk(tag, 32'(gpr_mem[i]), 32'(exp_regs[i]));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive();
  endtask

  task automatic set_alu(input logic [AW-1:0] d, input logic [DW-1:0] v);
    a_pend = 1'b1; a_dest = d; a_data = v; drive();
  endtask

  task automatic set_mem(input logic [AW-1:0] d, input logic [DW-1:0] v);
    m_pend = 1'b1; m_dest = d; m_data = v; drive();
  endtask

  initial begin
    a_pend = 0; m_pend = 0; a_rep = 0; m_rep = 0;
    a_dest = '0; m_dest = '0; a_data = '0; m_data = '0;
    clr_cnt = 0; last_mem = 1'b1;
    shown_we = 1'b0; shown_dest = '0; shown_data = '0;
    drive();
    step(); step();

    // Reset then idle through the clear sequence
    do_reset();
    repeat (10) step();
    check_regs("clear_regs");

    // ALU request held from reset, dest 3
    set_alu(3'd3, 16'h1234);
    do_reset();
    repeat (11) step();
    chk("r3_after_alu", 32'(gpr_mem[3]), 32'h1234);

    // Both requesters continuously re-presenting
    a_rep = 1; m_rep = 1;
    set_alu(3'd1, 16'hAAAA);
    set_mem(3'd2, 16'h5555);
    repeat (4) step();
    a_rep = 0; m_rep = 0; a_pend = 0; m_pend = 0; drive();
    step(); step();
    check_regs("dual_regs");

    // Writes to r0 handshake but never reach the file
    set_alu(3'd0, 16'hFFFF);
    repeat (3) step();
    chk("r0_zero", 32'(gpr_mem[0]), 32'h0000);

    // Reset during the fourth clear write with an ALU request pending
    set_alu(3'd6, 16'hBEEF);
    do_reset();
    repeat (3) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (11) step();
    chk("r6_after_restart", 32'(gpr_mem[6]), 32'hBEEF);

    // Same-destination race straight after a clear (last_grant = MEM)
    do_reset();
    repeat (8) step();
    set_alu(3'd5, 16'h0001);
    set_mem(3'd5, 16'h0002);
    repeat (4) step();
    chk("r5_race", 32'(gpr_mem[5]), 32'h0002);
    check_regs("race_regs");

    // Randomized traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      if (!a_pend && $urandom_range(0, 1) == 1) set_alu(AW'($urandom_range(0, NR-1)), DW'($urandom));
      if (!m_pend && $urandom_range(0, 1) == 1) set_mem(AW'($urandom_range(0, NR-1)), DW'($urandom));
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_n = 1'b1;
    a_pend = 0; m_pend = 0; drive();
    repeat (12) step();
    check_regs("random_regs");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
